action_sequencer: RTL and testbench
===================================

ACTION_SEQUENCER -- requirements
Module: action_sequencer

Interface
REQ-001 The block SHALL have parameter DWELL_CYCLES, default 50000000, meaning clock cycles each action code is displayed (minimum 1).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 12500000, meaning cycles of NOTHING shown between consecutive actions (0 = no gap).
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning command queue entries (power of two, minimum 2).
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all logic runs on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-006 The block SHALL have port cmd_valid, input, 1, meaning a command is offered.
REQ-007 The block SHALL have port cmd_code, input, 3, meaning the offered action code.
REQ-008 The block SHALL have port cmd_ready, output, 1, meaning the queue can accept (high when not full).
REQ-009 The block SHALL have port abort, input, 1, meaning flush queue and return to idle.
REQ-010 The block SHALL have port action, output, 3, meaning the code driven into the downstream 7-segment action decoder.
REQ-011 The block SHALL have port busy, output, 1, meaning high in SHOW or GAP or when the queue is non-empty.
REQ-012 The block SHALL have port err_code, output, 1, meaning a one-cycle pulse on an accepted-but-dropped invalid command.

Function
REQ-013 Action encoding SHALL be DN=000, A1=001, UP=010, A2=011, R1=100, R2=101, NOTHING=110; 111 is invalid.
REQ-014 A command SHALL be accepted on any cycle with cmd_valid and cmd_ready high.
REQ-015 Accepted codes 000-101 SHALL be enqueued; accepted 110 and 111 SHALL be discarded, and 111 SHALL pulse err_code for one cycle.
REQ-016 The FSM SHALL have states IDLE, SHOW and GAP.
REQ-017 In IDLE, action SHALL be NOTHING; with the queue non-empty, the FSM SHALL pop the head and enter SHOW on the next edge.
REQ-018 Latency from acceptance into an empty queue in IDLE to action showing the code SHALL be exactly 2 cycles.
REQ-019 SHOW SHALL drive the popped code for exactly DWELL_CYCLES cycles, then enter GAP (GAP_CYCLES>0) or proceed directly.
REQ-020 GAP SHALL drive NOTHING for exactly GAP_CYCLES cycles, then go to SHOW with the next entry if the queue is non-empty, otherwise to IDLE.
REQ-021 With GAP_CYCLES=0 and the queue non-empty at the end of SHOW, the next code SHALL appear on the following cycle with no NOTHING cycle in between.
REQ-022 A push and a pop in the same cycle SHALL both take effect; occupancy SHALL be unchanged and cmd_ready SHALL not drop.
REQ-023 When full, cmd_ready SHALL be low and offered commands SHALL be ignored (not lost silently: the upstream block holds them).
REQ-024 Queue pointers SHALL wrap modulo DEPTH; occupancy SHALL use $clog2(DEPTH)+1 bits.
REQ-025 The dwell/gap counter SHALL be sized for max(DWELL_CYCLES,GAP_CYCLES) and SHALL reload on every state entry.
REQ-026 abort SHALL, on the next edge, empty the queue, clear the counter, enter IDLE and force action to NOTHING; commands offered in the abort cycle SHALL be ignored.
REQ-027 abort SHALL take priority over push and pop.

Reset
REQ-028 On rst high at a clock edge, the FSM SHALL enter IDLE, the queue SHALL empty, and action=110, busy=0, err_code=0 and cmd_ready=1 after that edge.
REQ-029 rst SHALL take priority over abort and cmd_valid, including mid-SHOW and mid-GAP.
REQ-030 Action and busy SHALL be registered outputs, glitch-free to the decoder.

Structure
REQ-031 A shared package SHALL hold the seven action code constants and the FSM state encoding, shared with the 7-segment action decoder.
REQ-032 The queue SHALL be a separate sub-module named action_fifo (parameter DEPTH; push/pop/full/empty/flush).

Verification (DWELL_CYCLES=4, GAP_CYCLES=2, DEPTH=4 unless stated)
REQ-033 Reset, then push UP (010) once -> action 110,110,then 010 for 4 cycles, 110 for 2 cycles, IDLE, busy falls.
REQ-034 Push DN, A1, R1, R2, A2 back-to-back -> cmd_ready low after 4th or 5th per occupancy, none lost, display order 000,001,100,101,011, each 4 cycles separated by 2 NOTHING cycles.
REQ-035 Push 111 then 110 -> err_code pulses once, queue stays empty, action stays 110.
REQ-036 Abort during second cycle of SHOW with 2 entries queued -> next cycle action=110, busy=0, no further codes shown.
REQ-037 GAP_CYCLES=0, push A1 then A2 -> 001 for 4 cycles immediately followed by 011 for 4 cycles.
REQ-038 Queue full and a pop coinciding with a push -> both take effect, occupancy stays 4, order preserved.

Source files
------------

// File: rtl/action_sequencer_pkg.sv
// Shared action-code constants and sequencer state encoding, also used by the
// downstream 7-segment action decoder.
package action_sequencer_pkg;

   typedef logic [2:0] action_t;

   localparam action_t ACT_DN      = 3'b000;
   localparam action_t ACT_A1      = 3'b001;
   localparam action_t ACT_UP      = 3'b010;
   localparam action_t ACT_A2      = 3'b011;
   localparam action_t ACT_R1      = 3'b100;
   localparam action_t ACT_R2      = 3'b101;
   localparam action_t ACT_NOTHING = 3'b110;
   localparam action_t ACT_INVALID = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_SHOW = 2'b01,
      ST_GAP  = 2'b10
   } state_t;

   // Only real actions are worth queueing; NOTHING and the invalid code are dropped.
   function automatic logic is_displayable(input action_t code);
      case (code)
         ACT_DN, ACT_A1, ACT_UP, ACT_A2, ACT_R1, ACT_R2: is_displayable = 1'b1;
         default:                                        is_displayable = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/action_sequencer_if.sv
// Command handshake and display outputs of the action sequencer.
interface action_sequencer_if;
   import action_sequencer_pkg::*;

   logic    cmd_valid;
   action_t cmd_code;
   logic    cmd_ready;
   logic    abort;
   action_t action;
   logic    busy;
   logic    err_code;

   modport master (
      output cmd_valid, cmd_code, abort,
      input  cmd_ready, action, busy, err_code
   );

   modport slave (
      input  cmd_valid, cmd_code, abort,
      output cmd_ready, action, busy, err_code
   );

endinterface

// File: rtl/action_fifo.sv
// Small command queue: power-of-two depth, wrapping pointers, synchronous flush.
module action_fifo
   import action_sequencer_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  logic                   pop,
   input  action_t                din,
   output action_t                dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);

   action_t          mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   // A push into a full queue is legal only when a pop frees the slot this cycle.
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/action_sequencer.sv
// Queues action commands and displays each for a fixed dwell time, separated by
// an optional NOTHING gap; action and busy are registered for the decoder.
module action_sequencer
   import action_sequencer_pkg::*;
#(
   parameter int DWELL_CYCLES = 50000000,
   parameter int GAP_CYCLES   = 12500000,
   parameter int DEPTH        = 4
) (
   input logic               clk,
   input logic               rst,
   action_sequencer_if.slave bus
);

   localparam int MAX_CNT = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
   localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
   localparam int QW      = $clog2(DEPTH) + 1;
   localparam bit HAS_GAP = (GAP_CYCLES > 0);

   localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LOAD   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   action_t       act_q, act_n;
   logic          busy_q, busy_n;
   logic          err_q, err_n;

   logic          accept;
   logic          push;
   logic          pop;
   action_t       head;
   logic          q_full;
   logic          q_empty;
   logic [QW-1:0] q_count;

   action_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (bus.abort),
      .push  (push),
      .pop   (pop),
      .din   (bus.cmd_code),
      .dout  (head),
      .full  (q_full),
      .empty (q_empty),
      .count (q_count)
   );

   // pop depends only on registered state and abort, so ready has no path from cmd_valid.
   assign bus.cmd_ready = !q_full || pop;
   assign accept        = bus.cmd_valid && bus.cmd_ready && !bus.abort;
   assign push          = accept && is_displayable(bus.cmd_code);
   assign err_n         = accept && (bus.cmd_code == ACT_INVALID);
   assign busy_n        = !bus.abort &&
                          ((state_n != ST_IDLE) || (q_count > QW'(pop)) || push);

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      act_n   = act_q;
      pop     = 1'b0;

      case (state)
         ST_IDLE: begin
            act_n = ACT_NOTHING;
            if (!q_empty) begin
               pop     = 1'b1;
               state_n = ST_SHOW;
               cnt_n   = DWELL_LOAD;
               act_n   = head;
            end
         end

         ST_SHOW: begin
            if (cnt != '0) begin
               cnt_n = cnt - 1'b1;
            end else if (HAS_GAP) begin
               state_n = ST_GAP;
               cnt_n   = GAP_LOAD;
               act_n   = ACT_NOTHING;
            end else if (!q_empty) begin
               pop   = 1'b1;
               cnt_n = DWELL_LOAD;
               act_n = head;
            end else begin
               state_n = ST_IDLE;
               act_n   = ACT_NOTHING;
            end
         end

         ST_GAP: begin
            if (cnt != '0) begin
               cnt_n = cnt - 1'b1;
            end else if (!q_empty) begin
               pop     = 1'b1;
               state_n = ST_SHOW;
               cnt_n   = DWELL_LOAD;
               act_n   = head;
            end else begin
               state_n = ST_IDLE;
               act_n   = ACT_NOTHING;
            end
         end

         default: begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            act_n   = ACT_NOTHING;
         end
      endcase

      if (bus.abort) begin
         state_n = ST_IDLE;
         cnt_n   = '0;
         act_n   = ACT_NOTHING;
         pop     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         act_q  <= ACT_NOTHING;
         busy_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         act_q  <= act_n;
         busy_q <= busy_n;
         err_q  <= err_n;
      end
   end

   assign bus.action   = act_q;
   assign bus.busy     = busy_q;
   assign bus.err_code = err_q;

endmodule

// File: tb/tb_action_sequencer.sv
// Bench for action_sequencer: vector table, directed multi-cycle sequences and
// random traffic checked against a queue-based display model.
module tb_action_sequencer;

   localparam int DWELL = 4;
   localparam int GAP_A = 2;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   action_sequencer_if ifa();
   action_sequencer_if ifb();

   action_sequencer #(
      .DWELL_CYCLES (DWELL),
      .GAP_CYCLES   (GAP_A),
      .DEPTH        (DEPTH)
   ) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa.slave)
   );

   action_sequencer #(
      .DWELL_CYCLES (DWELL),
      .GAP_CYCLES   (0),
      .DEPTH        (DEPTH)
   ) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb.slave)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Display model for dut_a: a command list plus "what is on screen, for how much longer".
   int         mq[$];
   int         mmode = 0;   // 0 idle, 1 showing, 2 gap
   int         mleft = 0;   // cycles still to display in the current phase
   int         mcur  = 6;
   logic [2:0] m_act  = 3'd6;
   logic       m_busy = 1'b0;
   logic       m_err  = 1'b0;

   function automatic bit m_pop(input bit ab);
      if (ab || mq.size() == 0) return 1'b0;
      return (mmode == 0) || (mmode == 1 && mleft == 1 && GAP_A == 0) ||
             (mmode == 2 && mleft == 1);
   endfunction

   function automatic bit m_ready(input bit ab);
      return (mq.size() < DEPTH) || m_pop(ab);
   endfunction

   task automatic m_step(input bit r, input bit v, input logic [2:0] c, input bit ab);
      bit acc;
      if (r) begin
         mq.delete();
         mmode = 0; mleft = 0; m_act = 3'd6; m_busy = 1'b0; m_err = 1'b0;
         return;
      end
      acc   = v && m_ready(ab) && !ab;
      m_err = acc && (c == 3'd7);
      if (ab) begin
         mq.delete();
         mmode = 0; mleft = 0; m_act = 3'd6; m_busy = 1'b0;
         return;
      end
      if (mmode == 0) begin
         if (mq.size() > 0) begin
            mcur = mq.pop_front(); mmode = 1; mleft = DWELL;
         end
      end else begin
         mleft--;
         if (mleft == 0) begin
            if (mmode == 1 && GAP_A > 0) begin
               mmode = 2; mleft = GAP_A;
            end else if (mq.size() > 0) begin
               mcur = mq.pop_front(); mmode = 1; mleft = DWELL;
            end else begin
               mmode = 0;
            end
         end
      end
      if (acc && c < 3'd6) mq.push_back(int'(c));
      m_act  = (mmode == 1) ? 3'(mcur) : 3'd6;
      m_busy = (mmode != 0) || (mq.size() > 0);
   endtask

   logic [2:0] obs_a[$];
   logic [2:0] obs_b[$];
   logic       last_rdy_a;

   task automatic step(input bit r, input bit va, input logic [2:0] ca, input bit aba,
                       input bit vb, input logic [2:0] cb);
      rst = r;
      ifa.cmd_valid = va; ifa.cmd_code = ca; ifa.abort = aba;
      ifb.cmd_valid = vb; ifb.cmd_code = cb; ifb.abort = 1'b0;
      #1;
      last_rdy_a = ifa.cmd_ready;
      if (!r) chk("ready_model", 32'(ifa.cmd_ready), 32'(m_ready(aba)));
      @(posedge clk);
      m_step(r, va, ca, aba);
      #1;
      chk("action_model", 32'(ifa.action), 32'(m_act));
      chk("busy_model", 32'(ifa.busy), 32'(m_busy));
      chk("err_model", 32'(ifa.err_code), 32'(m_err));
      obs_a.push_back(ifa.action);
      obs_b.push_back(ifb.action);
   endtask

   task automatic step_a(input bit v, input logic [2:0] c, input bit ab);
      step(1'b0, v, c, ab, 1'b0, 3'd0);
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
      step(1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 3'd1);
      chk("rst_action", 32'(ifa.action), 32'd6);
      chk("rst_busy", 32'(ifa.busy), 32'd0);
      chk("rst_err", 32'(ifa.err_code), 32'd0);
      chk("rst_ready", 32'(ifa.cmd_ready), 32'd1);
      chk("rst_b_action", 32'(ifb.action), 32'd6);
   endtask

   // Splits an observed action trace into shown runs and checks code, length and gaps.
   task automatic check_runs(input string tag, input logic [2:0] obs[$], input int codes[$],
                             input int gap);
      int rc[$];
      int rl[$];
      int rg[$];
      int g = 0;
      for (int i = 0; i < obs.size(); i++) begin
         if (obs[i] == 3'd6) begin
            g++;
         end else if (rc.size() > 0 && g == 0 && obs[i-1] == obs[i]) begin
            rl[rl.size()-1] = rl[rl.size()-1] + 1;
         end else begin
            rc.push_back(int'(obs[i])); rl.push_back(1); rg.push_back(g); g = 0;
         end
      end
      chk({tag, "_runs"}, 32'(rc.size()), 32'(codes.size()));
      for (int k = 0; k < rc.size() && k < codes.size(); k++) begin
         chk($sformatf("%s_code%0d", tag, k), 32'(rc[k]), 32'(codes[k]));
         chk($sformatf("%s_len%0d", tag, k), 32'(rl[k]), 32'(DWELL));
         if (k > 0) chk($sformatf("%s_gap%0d", tag, k), 32'(rg[k]), 32'(gap));
      end
   endtask

   typedef struct {
      bit         v;
      logic [2:0] code;
      logic [2:0] e_act;
      bit         e_busy;
      bit         e_err;
   } vec_t;

   initial begin
      vec_t tbl[11];
      int   pl[$];
      int   q2[$];
      int   idx;
      bit   seen_low;
      bit   low_next;
      bit   offer;
      int   n_shown;

      // Single UP command, then invalid and NOTHING commands into an idle block.
      tbl[0]  = '{1'b1, 3'd2, 3'd6, 1'b1, 1'b0};
      tbl[1]  = '{1'b0, 3'd0, 3'd2, 1'b1, 1'b0};
      tbl[2]  = '{1'b0, 3'd0, 3'd2, 1'b1, 1'b0};
      tbl[3]  = '{1'b0, 3'd0, 3'd2, 1'b1, 1'b0};
      tbl[4]  = '{1'b0, 3'd0, 3'd2, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 3'd0, 3'd6, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 3'd0, 3'd6, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 3'd0, 3'd6, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 3'd7, 3'd6, 1'b0, 1'b1};
      tbl[9]  = '{1'b1, 3'd6, 3'd6, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 3'd0, 3'd6, 1'b0, 1'b0};

      do_reset();
      for (int i = 0; i < 11; i++) begin
         step_a(tbl[i].v, tbl[i].code, 1'b0);
         chk($sformatf("vec%0d_ready", i), 32'(last_rdy_a), 32'd1);
         chk($sformatf("vec%0d_action", i), 32'(ifa.action), 32'(tbl[i].e_act));
         chk($sformatf("vec%0d_busy", i), 32'(ifa.busy), 32'(tbl[i].e_busy));
         chk($sformatf("vec%0d_err", i), 32'(ifa.err_code), 32'(tbl[i].e_err));
      end

      // Back-to-back commands with the upstream holding while not ready; the last one
      // lands on a full queue in the same cycle as a pop.
      do_reset();
      obs_a.delete();
      pl = '{0, 1, 4, 5, 3, 2};
      idx = 0; seen_low = 1'b0; low_next = 1'b0;
      for (int cyc = 0; cyc < 60; cyc++) begin
         offer = (idx < pl.size());
         step_a(offer, offer ? 3'(pl[idx]) : 3'd0, 1'b0);
         if (low_next) begin
            chk("full_after_swap_ready", 32'(last_rdy_a), 32'd0);
            low_next = 1'b0;
         end
         if (offer && last_rdy_a) begin
            idx++;
            if (idx == pl.size()) low_next = 1'b1;
         end else if (offer) begin
            seen_low = 1'b1;
         end
      end
      chk("accepted_all", 32'(idx), 32'(pl.size()));
      chk("saw_ready_low", 32'(seen_low), 32'd1);
      check_runs("order", obs_a, pl, GAP_A);
      chk("order_busy_end", 32'(ifa.busy), 32'd0);

      // Abort during the second SHOW cycle with two entries queued.
      do_reset();
      step_a(1'b1, 3'd1, 1'b0);
      step_a(1'b1, 3'd4, 1'b0);
      step_a(1'b1, 3'd5, 1'b0);
      chk("pre_abort_action", 32'(ifa.action), 32'd1);
      step_a(1'b1, 3'd2, 1'b1);
      chk("abort_action", 32'(ifa.action), 32'd6);
      chk("abort_busy", 32'(ifa.busy), 32'd0);
      chk("abort_ready", 32'(ifa.cmd_ready), 32'd1);
      obs_a.delete();
      for (int i = 0; i < 20; i++) step_a(1'b0, 3'd0, 1'b0);
      n_shown = 0;
      foreach (obs_a[i]) if (obs_a[i] != 3'd6) n_shown++;
      chk("after_abort_shown", 32'(n_shown), 32'd0);

      // Reset wins over abort and a valid command in the middle of SHOW.
      step_a(1'b1, 3'd3, 1'b0);
      step_a(1'b0, 3'd0, 1'b0);
      step_a(1'b0, 3'd0, 1'b0);
      chk("pre_rst_action", 32'(ifa.action), 32'd3);
      step(1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 3'd0);
      chk("midshow_rst_action", 32'(ifa.action), 32'd6);
      chk("midshow_rst_busy", 32'(ifa.busy), 32'd0);
      step_a(1'b0, 3'd0, 1'b0);
      chk("midshow_rst_stays", 32'(ifa.action), 32'd6);

      // No-gap instance: consecutive codes must abut.
      do_reset();
      obs_b.delete();
      step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1);
      step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3);
      for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0);
      q2 = '{1, 3};
      check_runs("nogap", obs_b, q2, 0);
      chk("nogap_busy_end", 32'(ifb.busy), 32'd0);

      // Random traffic against the model, with occasional abort and reset.
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)), ($urandom_range(0, 39) == 0), 1'b0, 3'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
